// File: rtl/adc_sample_serializer_if.sv
// ---------------------------------------------------------------------------
// adc_sample_serializer_if
//   Word stream from the ADC sample serializer to the AXI4-Stream packetizer.
//   master : serializer side (drives data, valid, first/last, new_sample)
//   slave  : packetizer side (drives ready)
//   Signals:
//     s_tdata    serialized sample word
//     s_tvalid   word valid
//     s_tready   downstream ready
//     s_tfirst   word 0 of a sample
//     s_tlast    final word of a sample
//     new_sample one-cycle pulse when a buffered sample begins streaming
// ---------------------------------------------------------------------------
interface adc_sample_serializer_if #(
    parameter int DATA_WIDTH = 64
) ();
    logic [DATA_WIDTH-1:0] s_tdata;
    logic                  s_tvalid;
    logic                  s_tready;
    logic                  s_tfirst;
    logic                  s_tlast;
    logic                  new_sample;

    modport master (
        output s_tdata, s_tvalid, s_tfirst, s_tlast, new_sample,
        input  s_tready
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tfirst, s_tlast, new_sample,
        output s_tready
    );
endinterface

// File: rtl/adc_sample_serializer.sv
// ---------------------------------------------------------------------------
// adc_sample_serializer
//   Captures one parallel ADC sample (all channels) per strobe into a
//   two-entry ping-pong buffer and streams each sample out as a fixed group
//   of WORDS_PER_SAMPLE words. Samples arriving with both entries full are
//   dropped and counted.
//   Ports:
//     data_clk       ADC data clock, the only clock
//     data_rst       synchronous active-high reset
//     dma_ena        capture enable
//     dma_rst        synchronous active-high flush of buffers and counters
//     adc_data       parallel sample, channel c at [c*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//     adc_strobe     adc_data valid this cycle
//     s_axis         word stream towards the packetizer (master side)
//     overrun_flag   sticky: at least one sample dropped
//     overrun_count  saturating count of dropped samples
//     sample_count   count of captured samples, wraps
// ---------------------------------------------------------------------------
module adc_sample_serializer #(
    parameter int NUM_CHN          = 64,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int DATA_WIDTH       = 64,
    parameter int WORDS_PER_SAMPLE = NUM_CHN * SAMPLE_WIDTH / DATA_WIDTH,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                              data_clk,
    input  logic                              data_rst,
    input  logic                              dma_ena,
    input  logic                              dma_rst,
    input  logic [NUM_CHN*SAMPLE_WIDTH-1:0]   adc_data,
    input  logic                              adc_strobe,
    adc_sample_serializer_if.master           s_axis,
    output logic                              overrun_flag,
    output logic [CNT_WIDTH-1:0]              overrun_count,
    output logic [31:0]                       sample_count
);

    localparam int SAMPLE_BITS = NUM_CHN * SAMPLE_WIDTH;
    localparam int IDX_W       = (WORDS_PER_SAMPLE > 1) ? $clog2(WORDS_PER_SAMPLE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_SAMPLE - 1);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_e;

    state_e                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [SAMPLE_BITS-1:0]  buf_q [2];
    logic [1:0]              full_q;
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic                    new_sample_q;
    logic                    tvalid_q;
    logic                    tfirst_q;
    logic                    tlast_q;
    logic [DATA_WIDTH-1:0]   tdata_q;
    logic                    overrun_flag_q;
    logic [CNT_WIDTH-1:0]    overrun_count_q;
    logic [31:0]             sample_count_q;

    logic                    fin_d;
    logic                    wr_free_d;
    logic                    accept_d;
    logic                    drop_d;
    logic [IDX_W-1:0]        idx_d;
    logic [DATA_WIDTH-1:0]   word_d;

    always_comb begin
        fin_d     = 1'b0;
        wr_free_d = 1'b0;
        accept_d  = 1'b0;
        drop_d    = 1'b0;
        idx_d     = '0;
        word_d    = '0;

        fin_d = (state_q == STREAM) && s_axis.s_tready && (idx_q == IDX_LAST);
        // The entry being drained on the final handshake is reusable by a
        // strobe in the same cycle; with both entries full, wr and rd point
        // at the same entry.
        wr_free_d = !full_q[wr_ptr_q] || (fin_d && (rd_ptr_q == wr_ptr_q));
        accept_d  = adc_strobe && dma_ena && wr_free_d;
        drop_d    = adc_strobe && dma_ena && !wr_free_d;

        // Next word to present: word 0 when leaving LOAD, else the successor.
        idx_d  = (state_q == LOAD) ? '0 : idx_q + 1'b1;
        word_d = buf_q[rd_ptr_q][int'(idx_d)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge data_clk) begin
        if (data_rst || dma_rst) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            full_q          <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            new_sample_q    <= 1'b0;
            tvalid_q        <= 1'b0;
            tfirst_q        <= 1'b0;
            tlast_q         <= 1'b0;
            tdata_q         <= '0;
            overrun_flag_q  <= 1'b0;
            overrun_count_q <= '0;
            sample_count_q  <= '0;
        end else begin
            new_sample_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (full_q[rd_ptr_q]) begin
                        state_q      <= LOAD;
                        new_sample_q <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q  <= STREAM;
                    idx_q    <= idx_d;
                    tdata_q  <= word_d;
                    tvalid_q <= 1'b1;
                    tfirst_q <= 1'b1;
                    tlast_q  <= (idx_d == IDX_LAST);
                end
                STREAM: begin
                    if (s_axis.s_tready) begin
                        if (fin_d) begin
                            full_q[rd_ptr_q] <= 1'b0;
                            rd_ptr_q         <= ~rd_ptr_q;
                            state_q          <= IDLE;
                            tvalid_q         <= 1'b0;
                            tfirst_q         <= 1'b0;
                            tlast_q          <= 1'b0;
                        end else begin
                            idx_q    <= idx_d;
                            tdata_q  <= word_d;
                            tfirst_q <= 1'b0;
                            tlast_q  <= (idx_d == IDX_LAST);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Placed after the FSM so a same-cycle refill of the entry just
            // drained leaves it marked full.
            if (accept_d) begin
                buf_q[wr_ptr_q]  <= adc_data;
                full_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q         <= ~wr_ptr_q;
                sample_count_q   <= sample_count_q + 32'd1;
            end
            if (drop_d) begin
                overrun_flag_q <= 1'b1;
                if (overrun_count_q != '1) begin
                    overrun_count_q <= overrun_count_q + 1'b1;
                end
            end
        end
    end

    assign s_axis.s_tdata    = tdata_q;
    assign s_axis.s_tvalid   = tvalid_q;
    assign s_axis.s_tfirst   = tfirst_q;
    assign s_axis.s_tlast    = tlast_q;
    assign s_axis.new_sample = new_sample_q;
    assign overrun_flag      = overrun_flag_q;
    assign overrun_count     = overrun_count_q;
    assign sample_count      = sample_count_q;

endmodule

// File: tb/tb_adc_sample_serializer.sv
module tb_adc_sample_serializer;

    localparam int NC  = 64;
    localparam int SW  = 16;
    localparam int DW  = 64;
    localparam int WPS = 16;
    localparam int CW  = 16;
    localparam int AW  = NC * SW;

    logic          clk = 1'b0;
    logic          data_rst, dma_ena, dma_rst, adc_strobe;
    logic [AW-1:0] adc_data;
    logic          overrun_flag;
    logic [CW-1:0] overrun_count;
    logic [31:0]   sample_count;

    always #5 clk = ~clk;

    adc_sample_serializer_if #(.DATA_WIDTH(DW)) bus ();

    adc_sample_serializer #(
        .NUM_CHN(NC), .SAMPLE_WIDTH(SW), .DATA_WIDTH(DW),
        .WORDS_PER_SAMPLE(WPS), .CNT_WIDTH(CW)
    ) u_dut (
        .data_clk(clk), .data_rst(data_rst), .dma_ena(dma_ena), .dma_rst(dma_rst),
        .adc_data(adc_data), .adc_strobe(adc_strobe), .s_axis(bus),
        .overrun_flag(overrun_flag), .overrun_count(overrun_count),
        .sample_count(sample_count)
    );

    // Behavioural model: queue of buffered samples plus stream phase.
    logic [AW-1:0] mq[$];
    int            m_ph;      // 0 idle, 1 load, 2 streaming
    int            m_widx;
    logic [31:0]   m_scnt;
    int            m_ocnt;
    bit            m_oflag;

    int            vec, errs, cyc;
    logic [DW-1:0] got[$];
    int            fcnt, lcnt, ns_cyc, hs0_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int sz;
        if (data_rst || dma_rst) begin
            mq.delete();
            m_ph = 0; m_widx = 0; m_scnt = '0; m_ocnt = 0; m_oflag = 0;
        end else begin
            sz = mq.size();
            if (m_ph == 0) begin
                if (sz > 0) m_ph = 1;
            end else if (m_ph == 1) begin
                m_ph = 2; m_widx = 0;
            end else if (bus.s_tready) begin
                if (m_widx == WPS - 1) begin
                    void'(mq.pop_front());
                    m_ph = 0; m_widx = 0;
                end else begin
                    m_widx++;
                end
            end
            if (adc_strobe && dma_ena) begin
                if (mq.size() < 2) begin
                    mq.push_back(adc_data);
                    m_scnt = m_scnt + 32'd1;
                end else begin
                    if (m_ocnt < (1 << CW) - 1) m_ocnt++;
                    m_oflag = 1;
                end
            end
        end
    endtask

    task automatic compare();
        logic [AW-1:0] cur;
        logic [DW-1:0] ew;
        chk("tvalid", 64'(bus.s_tvalid), 64'(m_ph == 2));
        chk("new_sample", 64'(bus.new_sample), 64'(m_ph == 1));
        chk("tfirst", 64'(bus.s_tfirst), 64'(m_ph == 2 && m_widx == 0));
        chk("tlast", 64'(bus.s_tlast), 64'(m_ph == 2 && m_widx == WPS - 1));
        if (m_ph == 2) begin
            cur = mq[0];
            ew  = cur[m_widx*DW +: DW];
            chk("tdata", 64'(bus.s_tdata), 64'(ew));
        end
        chk("sample_count", 64'(sample_count), 64'(m_scnt));
        chk("overrun_count", 64'(overrun_count), 64'(m_ocnt));
        chk("overrun_flag", 64'(overrun_flag), 64'(m_oflag));
    endtask

    // One clock: log the handshake of the current cycle, advance the model,
    // take the edge, then check the new outputs.
    task automatic cycle();
        if (bus.s_tvalid && bus.s_tready) begin
            got.push_back(bus.s_tdata);
            if (got.size() == 1) hs0_cyc = cyc;
            if (bus.s_tfirst) fcnt++;
            if (bus.s_tlast) lcnt++;
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.new_sample) ns_cyc = cyc;
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic strobe(input logic [AW-1:0] d);
        adc_data = d; adc_strobe = 1'b1;
        cycle();
        adc_strobe = 1'b0;
    endtask

    task automatic wait_words(input int n, input string name);
        int k = 0;
        while (got.size() < n && k < 400) begin cycle(); k++; end
        chk(name, 64'(got.size() >= n), 64'd1);
    endtask

    task automatic flush_and_clear();
        dma_rst = 1'b1; cycle(); dma_rst = 1'b0;
        got.delete(); fcnt = 0; lcnt = 0; ns_cyc = -1; hs0_cyc = -1;
    endtask

    function automatic logic [AW-1:0] rand_sample();
        logic [AW-1:0] s;
        for (int i = 0; i < AW / 32; i++) s[i*32 +: 32] = $urandom();
        return s;
    endfunction

    initial begin
        logic [AW-1:0] s, ns;
        int t, k;
        vec = 0; errs = 0; cyc = 0;
        mq.delete(); m_ph = 0; m_widx = 0; m_scnt = '0; m_ocnt = 0; m_oflag = 0;
        data_rst = 1'b1; dma_rst = 1'b0; dma_ena = 1'b0; adc_strobe = 1'b0;
        adc_data = '0; bus.s_tready = 1'b0;
        run(3);
        chk("rst_tvalid", 64'(bus.s_tvalid), 64'd0);
        chk("rst_scnt", 64'(sample_count), 64'd0);
        chk("rst_oflag", 64'(overrun_flag), 64'd0);
        data_rst = 1'b0;
        flush_and_clear();

        // Single sample with literal word values and latency.
        dma_ena = 1'b1; bus.s_tready = 1'b1;
        for (int c = 0; c < NC; c++) s[c*SW +: SW] = 16'hC000 + 16'(c);
        t = cyc;
        strobe(s);
        wait_words(16, "single_timeout");
        run(3);
        chk("single_ns_lat", 64'(ns_cyc), 64'(t + 2));
        chk("single_hs0_lat", 64'(hs0_cyc), 64'(t + 3));
        chk("single_nwords", 64'(got.size()), 64'd16);
        chk("single_w0", 64'(got[0]), 64'hC003_C002_C001_C000);
        chk("single_w15", 64'(got[15]), 64'hC03F_C03E_C03D_C03C);
        chk("single_scnt", 64'(sample_count), 64'd1);

        // Backpressure pattern 1,0,0 repeating.
        flush_and_clear();
        strobe(rand_sample());
        for (int i = 0; i < 70; i++) begin
            bus.s_tready = (i % 3 == 0);
            cycle();
        end
        bus.s_tready = 1'b1;
        run(4);
        chk("bp_nwords", 64'(got.size()), 64'd16);
        chk("bp_first_once", 64'(fcnt), 64'd1);
        chk("bp_last_once", 64'(lcnt), 64'd1);

        // Overrun: four strobes with the sink stalled.
        flush_and_clear();
        bus.s_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin strobe(rand_sample()); cycle(); end
        chk("ovr_count", 64'(overrun_count), 64'd2);
        chk("ovr_flag", 64'(overrun_flag), 64'd1);
        chk("ovr_scnt", 64'(sample_count), 64'd2);
        bus.s_tready = 1'b1;
        run(60);
        chk("ovr_nwords", 64'(got.size()), 64'd32);

        // Strobe coincident with the final handshake while both buffers full.
        flush_and_clear();
        t = cyc;
        strobe(rand_sample()); cycle();
        strobe(rand_sample());
        k = 0;
        while (!(bus.s_tvalid && bus.s_tlast) && k < 100) begin cycle(); k++; end
        chk("bnd_last_cycle", 64'(cyc), 64'(t + 18));
        strobe(rand_sample());
        chk("bnd_no_overrun", 64'(overrun_flag), 64'd0);
        chk("bnd_scnt", 64'(sample_count), 64'd3);
        run(60);
        chk("bnd_nwords", 64'(got.size()), 64'd48);

        // dma_ena dropped mid-sample with second buffer full.
        flush_and_clear();
        strobe(rand_sample()); cycle();
        strobe(rand_sample());
        wait_words(5, "ena_w5_timeout");
        dma_ena = 1'b0;
        run(50);
        chk("ena_nwords", 64'(got.size()), 64'd32);
        strobe(rand_sample());
        run(10);
        chk("ena_ignored_scnt", 64'(sample_count), 64'd2);
        chk("ena_ignored_ocnt", 64'(overrun_count), 64'd0);
        chk("ena_ignored_nwords", 64'(got.size()), 64'd32);

        // Flush mid-group, then clean restart.
        dma_ena = 1'b1;
        flush_and_clear();
        strobe(rand_sample()); cycle();
        strobe(rand_sample()); cycle();
        strobe(rand_sample());
        chk("fl_flag_set", 64'(overrun_flag), 64'd1);
        wait_words(7, "fl_w7_timeout");
        dma_rst = 1'b1; cycle(); dma_rst = 1'b0;
        chk("fl_tvalid", 64'(bus.s_tvalid), 64'd0);
        chk("fl_scnt", 64'(sample_count), 64'd0);
        chk("fl_ocnt", 64'(overrun_count), 64'd0);
        chk("fl_flag", 64'(overrun_flag), 64'd0);
        got.delete(); fcnt = 0; lcnt = 0;
        ns = rand_sample();
        strobe(ns);
        wait_words(16, "fl_restart_timeout");
        chk("fl_restart_w0", 64'(got[0]), 64'(ns[63:0]));
        chk("fl_restart_first", 64'(fcnt), 64'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) dma_ena = ~dma_ena;
            dma_rst      = ($urandom_range(0, 399) == 0);
            bus.s_tready = ($urandom_range(0, 9) < 7);
            adc_strobe   = ($urandom_range(0, 5) == 0);
            if (adc_strobe) adc_data = rand_sample();
            cycle();
        end
        adc_strobe = 1'b0; dma_rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/adc_sample_serializer.md
Name: adc_sample_serializer

Overview:
- Upstream neighbour of the AXI4-Stream packetizer in the ADC C2H path. Runs in the 40 MHz ADC data clock domain.
- Captures one full parallel ADC sample (all channels) per ADC strobe into a two-deep sample buffer.
- Serializes each sample into a fixed group of 64-bit words with a valid/ready handshake.
- Drives the packetizer's new_sample input and word data. Counts dropped samples on overrun.

Parameters:
- NUM_CHN, 64, number of ADC channels per sample.
- SAMPLE_WIDTH, 16, bits per channel sample.
- DATA_WIDTH, 64, output word width.
- WORDS_PER_SAMPLE, NUM_CHN*SAMPLE_WIDTH/DATA_WIDTH (=16), output words per sample. Must be an integer and a power of 2.
- CNT_WIDTH, 16, overrun counter width.

Ports:
- data_clk  in  1  ADC data clock (40 MHz); the only clock.
- data_rst  in  1  synchronous active-high reset.
- dma_ena  in  1  capture enable.
- dma_rst  in  1  synchronous active-high flush of buffers and counters.
- adc_data  in  NUM_CHN*SAMPLE_WIDTH  parallel sample; channel c at bits [c*16+15:c*16].
- adc_strobe  in  1  one-cycle pulse: adc_data is valid this cycle.
- new_sample  out  1  one-cycle pulse when a buffered sample begins streaming.
- s_tdata  out  DATA_WIDTH  serialized word.
- s_tvalid  out  1  word valid.
- s_tready  in  1  downstream ready.
- s_tfirst  out  1  high on word 0 of a sample.
- s_tlast  out  1  high on word WORDS_PER_SAMPLE-1 of a sample.
- overrun_flag  out  1  sticky: at least one sample was dropped.
- overrun_count  out  CNT_WIDTH  saturating count of dropped samples.
- sample_count  out  32  count of samples captured; wraps at 2^32.

Behaviour:
- Reset (data_rst=1): all outputs 0, both buffers empty, FSM in IDLE, write/read pointers 0.
- Takes effect at the next data_clk edge.
- Buffering:
  - Two sample registers, full/empty bit each, ping-pong write and read pointers.
  - On adc_strobe=1 with dma_ena=1 and the write buffer empty: latch adc_data, mark it full, toggle the write pointer, increment sample_count.
  - On adc_strobe with both buffers full: drop the sample, set overrun_flag, increment overrun_count (saturates at all-ones). sample_count is unchanged.
  - A buffer freed on the final-word handshake in cycle t counts as empty for a strobe in the same cycle t.
  - adc_strobe while dma_ena=0 is ignored: no count, no overrun.
- FSM states:
  - IDLE: if the read buffer is full, go to LOAD.
  - LOAD: pulse new_sample=1 for exactly one cycle, word index=0, go to STREAM.
  - STREAM: s_tvalid=1. On s_tvalid&&s_tready, increment the word index. At index WORDS_PER_SAMPLE-1 with handshake: mark the read buffer empty, toggle the read pointer, go to IDLE.
- Latency: adc_strobe at cycle t into an empty system gives new_sample at t+2 and s_tvalid from t+3. Back-to-back full buffers cost two idle cycles (IDLE, LOAD) between samples.
- Word k contains channels 4k..4k+3, with channel 4k in bits [15:0] and channel 4k+3 in bits [63:48].
- s_tfirst = STREAM && index==0. s_tlast = STREAM && index==WORDS_PER_SAMPLE-1.
- s_tdata, s_tvalid, s_tfirst, s_tlast hold stable while s_tvalid=1 and s_tready=0. No word is skipped or repeated.
- dma_ena falling mid-sample: the current sample and any already-buffered sample are streamed to completion. Groups are never truncated.
- dma_rst=1: next cycle both buffers are empty, FSM is in IDLE, s_tvalid=0, and all counters and overrun_flag are 0. This may truncate a group in flight; the downstream packetizer is flushed by the same signal.
- data_rst and dma_rst both take priority over adc_strobe in the same cycle.

Test Plan:
- Single sample: dma_ena=1, channel c = 16'hC000+c, one strobe, s_tready=1 → new_sample at t+2; 16 words from t+3; word 0 = 64'hC003_C002_C001_C000; s_tlast on word 15 = 64'hC03F_C03E_C03D_C03C; sample_count=1.
- Backpressure: s_tready toggled 1,0,0,1,... during stream → every word appears exactly once in order; data is stable while stalled; s_tfirst and s_tlast are each asserted only once.
- Overrun: s_tready=0 and 4 strobes → first 2 buffered; overrun_count=2, overrun_flag=1, sample_count=2. Release s_tready → exactly 32 words out.
- Boundary: strobe in the same cycle as the final handshake with both buffers full → the strobe is accepted, with no overrun.
- dma_ena low: dma_ena dropped at word 5 with the second buffer full → both samples (32 words) complete. A later strobe is ignored and counts are unchanged.
- Flush: dma_rst at word 7 → s_tvalid=0 next cycle, counters 0, flag cleared. A new strobe restarts cleanly at word 0 with s_tfirst=1.
